frontend_test_checker: RTL and testbench

//  Receive-side checker for the front-end test stream: consumes frontEnd_valid + L/R 24-bit samples,

---
 rtl/frontend_test_checker_if.sv | 12 +
 rtl/frontend_test_checker.sv | 212 +++++++++++++++++++++
 tb/tb_frontend_test_checker.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frontend_test_checker_if.sv
// Sample stream from the front-end mux: one-clock strobe with left/right samples.
`timescale 1ns/1ps
interface frontend_test_checker_if #(
    parameter int DATA_W = 24
);
    logic              frontEnd_valid;
    logic [DATA_W-1:0] l_frontEnd_data;
    logic [DATA_W-1:0] r_frontEnd_data;

    modport master (output frontEnd_valid, l_frontEnd_data, r_frontEnd_data);
    modport slave  (input  frontEnd_valid, l_frontEnd_data, r_frontEnd_data);
endinterface

// File: rtl/frontend_test_checker.sv
// Receive-side checker for the front-end test stream: pattern check, L/R compare,
// strobe-interval measurement and signed min/max of the left channel.
`timescale 1ns/1ps
module frontend_test_checker #(
    parameter int          DATA_W       = 24,
    parameter int          CNT_W        = 16,
    parameter int          INTV_W       = 12,
    parameter int unsigned TIMEOUT_CLKS = 32'hfff
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [3:0]               data_out_select,
    input  logic [7:0]               triangle_inc_reg,
    input  logic [9:0]               impulse_period,
    frontend_test_checker_if.slave   fe,
    output logic [CNT_W-1:0]         sample_count,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W-1:0]         lr_err_count,
    output logic [INTV_W-1:0]        smp_interval,
    output logic [DATA_W-1:0]        data_max,
    output logic [DATA_W-1:0]        data_min,
    output logic                     interval_err,
    output logic                     timeout,
    output logic                     locked,
    output logic                     status_valid
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOST} state_e;

    localparam logic [DATA_W-1:0] IMPULSE_VAL = DATA_W'(24'h7fff00);
    localparam logic [DATA_W-1:0] MAX_RESET   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MIN_RESET   = {1'b0, {(DATA_W-1){1'b1}}};

    state_e              state_q, state_d;
    logic [3:0]          sel_q;
    logic [INTV_W-1:0]   intvCnt_q, smpInterval_q, intvNext;
    logic                intvValid_q, intervalErr_q, timeout_q, statusValid_q;
    logic [DATA_W-1:0]   prevL_q, dataMax_q, dataMin_q;
    logic [9:0]          impCnt_q;
    logic                impSeen_q;
    logic [CNT_W-1:0]    sampleCnt_q, errCnt_q, lrErrCnt_q;

    logic                strobe, restart, acqStrobe, trackStrobe, timeoutHit, lostEntry;
    logic [DATA_W-1:0]   sampleL, sampleR, constExp, triStep;
    logic signed [DATA_W:0] triDiff;
    logic [DATA_W:0]     triAbs;
    logic                modeHasConst, patErr, lrErr;

    assign strobe      = fe.frontEnd_valid;
    assign sampleL     = fe.l_frontEnd_data;
    assign sampleR     = fe.r_frontEnd_data;
    assign triStep     = DATA_W'({triangle_inc_reg, 13'h0});
    assign restart     = (state_q != IDLE) && (clear || (data_out_select != sel_q));
    assign acqStrobe   = enable && strobe && !restart && (state_q == ACQ);
    assign trackStrobe = enable && strobe && !restart && (state_q == TRACK);
    assign timeoutHit  = (intvCnt_q == INTV_W'(TIMEOUT_CLKS));
    assign intvNext    = (intvCnt_q == '1) ? intvCnt_q : intvCnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= data_out_select;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (restart) begin
            state_d = ACQ;
        end else begin
            case (state_q)
                IDLE:    state_d = ACQ;
                ACQ:     if (strobe) state_d = TRACK;
                TRACK:   if (!strobe && timeoutHit) state_d = LOST;
                LOST:    if (strobe) state_d = ACQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        locked    = (state_q == TRACK);
        lostEntry = (state_q == TRACK) && (state_d == LOST);
    end

    // Triangle steps are compared on the true signed difference so zero crossings stay exact.
    always_comb begin
        constExp     = '0;
        modeHasConst = 1'b0;
        patErr       = 1'b0;
        triDiff      = $signed({sampleL[DATA_W-1], sampleL}) - $signed({prevL_q[DATA_W-1], prevL_q});
        triAbs       = triDiff[DATA_W] ? (~triDiff + 1'b1) : triDiff;
        case (data_out_select)
            4'd1:    begin modeHasConst = 1'b1; constExp = DATA_W'(24'h000100); end
            4'd2:    begin modeHasConst = 1'b1; constExp = DATA_W'(24'hffff00); end
            4'd3:    begin modeHasConst = 1'b1; constExp = DATA_W'(24'h7fff00); end
            4'd4:    begin modeHasConst = 1'b1; constExp = DATA_W'(24'h8000ff); end
            default: ;
        endcase
        if (modeHasConst) begin
            patErr = (sampleL != constExp) || (sampleR != constExp);
        end else if (data_out_select == 4'd5) begin
            patErr = (triStep == '0) || (triAbs != {1'b0, triStep});
        end else if (data_out_select == 4'd6) begin
            patErr = (sampleL != '0) && ((sampleL != IMPULSE_VAL) ||
                     (impSeen_q && (({1'b0, impCnt_q} + 11'd1) != {1'b0, impulse_period})));
        end
        lrErr = (data_out_select >= 4'd1) && (data_out_select <= 4'd6) && (sampleL != sampleR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            intvCnt_q     <= '0;
            smpInterval_q <= '0;
            intvValid_q   <= 1'b0;
            intervalErr_q <= 1'b0;
        end else begin
            if (acqStrobe || trackStrobe)
                intvCnt_q <= '0;
            else if ((state_q == TRACK) || (state_q == LOST))
                intvCnt_q <= intvNext;
            else
                intvCnt_q <= '0;
            if (trackStrobe) begin
                smpInterval_q <= intvNext;
                intvValid_q   <= 1'b1;
            end else if (state_q != TRACK) begin
                intvValid_q   <= 1'b0;
            end
            if (clear)
                intervalErr_q <= 1'b0;
            else if (trackStrobe && intvValid_q && (intvNext != smpInterval_q))
                intervalErr_q <= 1'b1;
        end
    end

    // Impulse spacing restarts on every acquisition, so the first impulse only seeds the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prevL_q   <= '0;
            impCnt_q  <= '0;
            impSeen_q <= 1'b0;
        end else if (acqStrobe) begin
            prevL_q   <= sampleL;
            impCnt_q  <= '0;
            impSeen_q <= 1'b0;
        end else if (trackStrobe) begin
            prevL_q <= sampleL;
            if (sampleL != '0) begin
                impCnt_q  <= '0;
                impSeen_q <= 1'b1;
            end else if (impCnt_q != '1) begin
                impCnt_q  <= impCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sampleCnt_q   <= '0;
            errCnt_q      <= '0;
            lrErrCnt_q    <= '0;
            dataMax_q     <= MAX_RESET;
            dataMin_q     <= MIN_RESET;
            timeout_q     <= 1'b0;
            statusValid_q <= 1'b0;
        end else begin
            statusValid_q <= trackStrobe;
            if (clear) begin
                sampleCnt_q <= '0;
                errCnt_q    <= '0;
                lrErrCnt_q  <= '0;
                dataMax_q   <= MAX_RESET;
                dataMin_q   <= MIN_RESET;
                timeout_q   <= 1'b0;
            end else begin
                if (lostEntry)
                    timeout_q <= 1'b1;
                if (trackStrobe) begin
                    if (sampleCnt_q != '1)
                        sampleCnt_q <= sampleCnt_q + 1'b1;
                    if (patErr && (errCnt_q != '1))
                        errCnt_q <= errCnt_q + 1'b1;
                    if (lrErr && (lrErrCnt_q != '1))
                        lrErrCnt_q <= lrErrCnt_q + 1'b1;
                    if ($signed(sampleL) > $signed(dataMax_q))
                        dataMax_q <= sampleL;
                    if ($signed(sampleL) < $signed(dataMin_q))
                        dataMin_q <= sampleL;
                end
            end
        end
    end

    assign sample_count = sampleCnt_q;
    assign err_count    = errCnt_q;
    assign lr_err_count = lrErrCnt_q;
    assign smp_interval = smpInterval_q;
    assign data_max     = dataMax_q;
    assign data_min     = dataMin_q;
    assign interval_err = intervalErr_q;
    assign timeout      = timeout_q;
    assign status_valid = statusValid_q;

endmodule

// File: tb/tb_frontend_test_checker.sv
// Directed bench for frontend_test_checker: expected counter snapshots are queued per
// tracked strobe and popped by an independent monitor whenever status_valid is seen.
`timescale 1ns/1ps
module tb_frontend_test_checker;

    localparam int DATA_W   = 24;
    localparam int CNT_W    = 8;
    localparam int INTV_W   = 12;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int TRI_STEP = 32'h2a000;

    typedef struct {
        int sampleCnt;
        int errCnt;
        int lrCnt;
    } expect_t;

    expect_t sbQueue[$];
    int checks = 0;
    int errors = 0;
    int expSample = 0;
    int expErr = 0;
    int expLr = 0;
    int triV = 0;
    int triDir = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic [3:0] sel = 4'd0;
    logic [7:0] incReg = 8'd0;
    logic [9:0] impPeriod = 10'd0;

    logic [CNT_W-1:0]  sample_count, err_count, lr_err_count;
    logic [INTV_W-1:0] smp_interval;
    logic [DATA_W-1:0] data_max, data_min;
    logic interval_err, timeout, locked, status_valid;

    frontend_test_checker_if #(.DATA_W(DATA_W)) feIf();

    frontend_test_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .INTV_W(INTV_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .clear            (clear),
        .data_out_select  (sel),
        .triangle_inc_reg (incReg),
        .impulse_period   (impPeriod),
        .fe               (feIf),
        .sample_count     (sample_count),
        .err_count        (err_count),
        .lr_err_count     (lr_err_count),
        .smp_interval     (smp_interval),
        .data_max         (data_max),
        .data_min         (data_min),
        .interval_err     (interval_err),
        .timeout          (timeout),
        .locked           (locked),
        .status_valid     (status_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bumpExpected(input bit isErr, input bit isLr);
        expect_t e;
        if (expSample < CNT_MAX) expSample++;
        if (isErr && (expErr < CNT_MAX)) expErr++;
        if (isLr && (expLr < CNT_MAX)) expLr++;
        e.sampleCnt = expSample;
        e.errCnt    = expErr;
        e.lrCnt     = expLr;
        sbQueue.push_back(e);
    endtask

    // One strobe, then gap idle clocks: strobe-to-strobe interval is gap+1.
    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input int gap,
                                 input bit tracked, input bit isErr, input bit isLr);
        feIf.l_frontEnd_data = l;
        feIf.r_frontEnd_data = r;
        feIf.frontEnd_valid  = 1'b1;
        if (tracked) bumpExpected(isErr, isLr);
        @(posedge clk); #1;
        feIf.frontEnd_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic idleClocks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic triAdvance();
        if (triDir > 0) begin
            if (triV + TRI_STEP > 8388607) begin triDir = -1; triV = triV - TRI_STEP; end
            else triV = triV + TRI_STEP;
        end else begin
            if (triV - TRI_STEP < -8388608) begin triDir = 1; triV = triV + TRI_STEP; end
            else triV = triV - TRI_STEP;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_sample_count"}, 32'(sample_count), 0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 0);
        checkOutput({tag, "_lr_err_count"}, 32'(lr_err_count), 0);
        checkOutput({tag, "_smp_interval"}, 32'(smp_interval), 0);
        checkOutput({tag, "_data_max"}, 32'(data_max), 32'h800000);
        checkOutput({tag, "_data_min"}, 32'(data_min), 32'h7fffff);
        checkOutput({tag, "_interval_err"}, 32'(interval_err), 0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 0);
        checkOutput({tag, "_locked"}, 32'(locked), 0);
        checkOutput({tag, "_status_valid"}, 32'(status_valid), 0);
    endtask

    always @(negedge clk) begin : monitor
        expect_t e;
        if (reset_n && status_valid) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected_status: got status_valid=1, expected no pending result");
            end else begin
                e = sbQueue.pop_front();
                checkOutput("sb_sample_count", 32'(sample_count), e.sampleCnt);
                checkOutput("sb_err_count", 32'(err_count), e.errCnt);
                checkOutput("sb_lr_err_count", 32'(lr_err_count), e.lrCnt);
            end
        end
    end

    initial begin
        logic [23:0] l;
        feIf.frontEnd_valid  = 1'b0;
        feIf.l_frontEnd_data = '0;
        feIf.r_frontEnd_data = '0;
        idleClocks(3);
        checkResetState("reset");

        // Mode 3 at the 44.1k strobe rate
        reset_n = 1'b1;
        enable  = 1'b1;
        sel     = 4'd3;
        idleClocks(2);
        checkOutput("t1_locked_in_acq", 32'(locked), 0);
        applyStimulus(24'h7fff00, 24'h7fff00, 1114, 0, 0, 0);
        for (int i = 0; i < 11; i++) applyStimulus(24'h7fff00, 24'h7fff00, 1114, 1, 0, 0);
        checkOutput("t1_sample_count", 32'(sample_count), 11);
        checkOutput("t1_err_count", 32'(err_count), 0);
        checkOutput("t1_smp_interval", 32'(smp_interval), 1115);
        checkOutput("t1_locked", 32'(locked), 1);
        checkOutput("t1_data_max", 32'(data_max), 32'h7fff00);
        checkOutput("t1_data_min", 32'(data_min), 32'h7fff00);

        // Mode 1 with one corrupted left sample
        sel = 4'd1;
        idleClocks(2);
        applyStimulus(24'h000100, 24'h000100, 7, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(24'h000100, 24'h000100, 7, 1, 0, 0);
        feIf.l_frontEnd_data = 24'h000101;
        feIf.r_frontEnd_data = 24'h000100;
        feIf.frontEnd_valid  = 1'b1;
        bumpExpected(1, 1);
        @(posedge clk); #1;
        feIf.frontEnd_valid = 1'b0;
        checkOutput("t2_status_pulse", 32'(status_valid), 1);
        checkOutput("t2_err_count", 32'(err_count), 1);
        checkOutput("t2_lr_err_count", 32'(lr_err_count), 1);
        idleClocks(1);
        checkOutput("t2_status_drop", 32'(status_valid), 0);
        idleClocks(6);
        applyStimulus(24'h000100, 24'h000100, 7, 1, 0, 0);

        // Mode 5 triangle, step 0x2a000, through both turnarounds
        sel    = 4'd5;
        incReg = 8'h15;
        idleClocks(2);
        triV   = 0;
        triDir = 1;
        applyStimulus(24'(triV), 24'(triV), 3, 0, 0, 0);
        for (int i = 1; i < 300; i++) begin
            triAdvance();
            applyStimulus(24'(triV), 24'(triV), 3, 1, 0, 0);
        end
        triAdvance();
        triAdvance();
        applyStimulus(24'(triV), 24'(triV), 3, 1, 1, 0);
        triAdvance();
        applyStimulus(24'(triV), 24'(triV), 3, 1, 0, 0);
        incReg = 8'h00;
        applyStimulus(24'(triV), 24'(triV), 3, 1, 1, 0);
        applyStimulus(24'(triV), 24'(triV), 3, 1, 1, 0);
        checkOutput("t3_err_count", 32'(err_count), 4);
        checkOutput("t3_lr_err_count", 32'(lr_err_count), 1);
        checkOutput("t3_data_max", 32'(data_max), 32'h7fff00);
        checkOutput("t3_data_min", 32'(data_min), 32'h820000);
        checkOutput("t3_interval_err", 32'(interval_err), 0);

        // Mode 6 impulses at strobes 1,11,21 then late at 32, bad value at 42
        sel       = 4'd6;
        impPeriod = 10'd10;
        idleClocks(2);
        applyStimulus(24'h0, 24'h0, 3, 0, 0, 0);
        for (int i = 1; i <= 45; i++) begin
            l = 24'h0;
            if (i == 1 || i == 11 || i == 21 || i == 32) l = 24'h7fff00;
            if (i == 42) l = 24'h123456;
            applyStimulus(l, l, 3, 1, (i == 32 || i == 42), 0);
        end
        checkOutput("t4_err_count", 32'(err_count), 6);
        checkOutput("t4_interval_err", 32'(interval_err), 0);

        // Strobe loss, recovery and an interval change
        sel = 4'd3;
        idleClocks(2);
        applyStimulus(24'h7fff00, 24'h7fff00, 1114, 0, 0, 0);
        applyStimulus(24'h7fff00, 24'h7fff00, 1114, 1, 0, 0);
        applyStimulus(24'h7fff00, 24'h7fff00, 4090, 1, 0, 0);
        checkOutput("t5_locked_before_loss", 32'(locked), 1);
        checkOutput("t5_timeout_before_loss", 32'(timeout), 0);
        idleClocks(10);
        checkOutput("t5_timeout", 32'(timeout), 1);
        checkOutput("t5_locked_lost", 32'(locked), 0);
        applyStimulus(24'h7fff00, 24'h7fff00, 9, 0, 0, 0);
        checkOutput("t5_locked_reacq", 32'(locked), 0);
        applyStimulus(24'h7fff00, 24'h7fff00, 1114, 0, 0, 0);
        checkOutput("t5_locked_track", 32'(locked), 1);
        applyStimulus(24'h7fff00, 24'h7fff00, 1114, 1, 0, 0);
        applyStimulus(24'h7fff00, 24'h7fff00, 1115, 1, 0, 0);
        checkOutput("t5_interval_err_steady", 32'(interval_err), 0);
        applyStimulus(24'h7fff00, 24'h7fff00, 5, 1, 0, 0);
        checkOutput("t5_interval_err", 32'(interval_err), 1);
        checkOutput("t5_smp_interval", 32'(smp_interval), 1116);

        // Saturation, clear coincident with a strobe, then async reset mid-run
        sel = 4'd1;
        idleClocks(2);
        applyStimulus(24'h0, 24'h0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) applyStimulus(24'h0, 24'h0, (i == 259) ? 3 : 0, 1, 1, 0);
        checkOutput("t6_err_saturated", 32'(err_count), CNT_MAX);
        checkOutput("t6_timeout_sticky", 32'(timeout), 1);
        clear                = 1'b1;
        feIf.l_frontEnd_data = 24'h000100;
        feIf.r_frontEnd_data = 24'h000100;
        feIf.frontEnd_valid  = 1'b1;
        @(posedge clk); #1;
        clear               = 1'b0;
        feIf.frontEnd_valid = 1'b0;
        expSample = 0;
        expErr    = 0;
        expLr     = 0;
        checkOutput("t6_clear_sample_count", 32'(sample_count), 0);
        checkOutput("t6_clear_err_count", 32'(err_count), 0);
        checkOutput("t6_clear_lr_err_count", 32'(lr_err_count), 0);
        checkOutput("t6_clear_timeout", 32'(timeout), 0);
        checkOutput("t6_clear_interval_err", 32'(interval_err), 0);
        checkOutput("t6_clear_data_max", 32'(data_max), 32'h800000);
        checkOutput("t6_clear_data_min", 32'(data_min), 32'h7fffff);
        checkOutput("t6_clear_locked", 32'(locked), 0);
        idleClocks(2);
        applyStimulus(24'h000100, 24'h000100, 3, 0, 0, 0);
        checkOutput("t6_relock", 32'(locked), 1);
        checkOutput("t6_relock_sample_count", 32'(sample_count), 0);
        for (int i = 0; i < 3; i++) applyStimulus(24'h000100, 24'h000100, 3, 1, 0, 0);
        checkOutput("t6_sample_count", 32'(sample_count), 3);
        checkOutput("t6_data_max", 32'(data_max), 32'h000100);
        checkOutput("t6_data_min", 32'(data_min), 32'h000100);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetState("midrun_reset");
        checkOutput("sb_drained", 32'(sbQueue.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
